// File: rtl/yc_noc_mem_responder.sv
// yc_noc_mem_responder: NoC target endpoint that terminates CPU memory
// requests. It accepts READ_REQ/WRITE_REQ flits addressed to this node,
// accesses a word-addressed memory, and returns READ_RESP/WRITE_ACK to the
// requester. One request is outstanding at a time.

package yc_noc_defs;
  localparam logic [3:0] OP_READ_REQ  = 4'h1;
  localparam logic [3:0] OP_WRITE_REQ = 4'h2;
  localparam logic [3:0] OP_READ_RESP = 4'h3;
  localparam logic [3:0] OP_WRITE_ACK = 4'h4;

  typedef struct packed {
    logic [3:0]  opc;
    logic [3:0]  src_x;
    logic [3:0]  src_y;
    logic [3:0]  dst_x;
    logic [3:0]  dst_y;
    logic [31:0] addr;
    logic [31:0] data;
  } flit_t;

  function automatic logic [3:0] flit_opc(input flit_t f);
    return f.opc;
  endfunction
  function automatic logic [3:0] flit_src_x(input flit_t f);
    return f.src_x;
  endfunction
  function automatic logic [3:0] flit_src_y(input flit_t f);
    return f.src_y;
  endfunction
  function automatic logic [3:0] flit_dst_x(input flit_t f);
    return f.dst_x;
  endfunction
  function automatic logic [3:0] flit_dst_y(input flit_t f);
    return f.dst_y;
  endfunction
  function automatic logic [31:0] flit_addr(input flit_t f);
    return f.addr;
  endfunction
  function automatic logic [31:0] flit_data(input flit_t f);
    return f.data;
  endfunction
endpackage

module yc_noc_mem_responder
  import yc_noc_defs::*;
#(
  parameter int MY_X     = 1,
  parameter int MY_Y     = 0,
  parameter int DEPTH    = 256,
  parameter int RESP_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  flit_t       rx_flit,
  output logic        tx_valid,
  input  logic        tx_ready,
  output flit_t       tx_flit,
  output logic        busy,
  output logic [15:0] req_cnt,
  output logic [15:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [3:0] MY_X_C = 4'(MY_X);
  localparam logic [3:0] MY_Y_C = 4'(MY_Y);
  localparam logic [3:0] LAT_C  = 4'(RESP_LAT);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]    state_q, state_d;
  flit_t         req_q, req_d;
  flit_t         tx_flit_q, tx_flit_d;
  logic          tx_valid_q, tx_valid_d;
  logic [3:0]    lat_q, lat_d;
  logic [15:0]   req_cnt_q, req_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx_s;
  logic          rx_fire_s;
  logic          req_good_s;
  logic          is_write_s;
  logic          mem_we_s;

  assign rx_ready = (state_q == S_IDLE) && !rst;
  assign tx_valid = tx_valid_q;
  assign tx_flit  = tx_flit_q;
  assign busy     = (state_q != S_IDLE);
  assign req_cnt  = req_cnt_q;
  assign err_cnt  = err_cnt_q;

  assign rx_fire_s  = rx_valid && rx_ready;
  assign req_good_s = (flit_dst_x(rx_flit) == MY_X_C) && (flit_dst_y(rx_flit) == MY_Y_C) &&
                      ((flit_opc(rx_flit) == OP_READ_REQ) || (flit_opc(rx_flit) == OP_WRITE_REQ));
  // Upper address bits are dropped, so the memory aliases every DEPTH words.
  assign idx_s      = flit_addr(req_q)[AW-1:0];
  assign is_write_s = (flit_opc(req_q) == OP_WRITE_REQ);

  // Next-state logic for the request FSM, counters and response register.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    tx_flit_d  = tx_flit_q;
    tx_valid_d = tx_valid_q;
    lat_d      = lat_q;
    req_cnt_d  = req_cnt_q;
    err_cnt_d  = err_cnt_q;
    mem_we_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_fire_s) begin
          req_d = rx_flit;
          if (req_good_s) begin
            state_d   = S_ACCESS;
            req_cnt_d = sat_inc(req_cnt_q);
          end else begin
            // Misrouted or unknown flits are swallowed without a reply.
            err_cnt_d = sat_inc(err_cnt_q);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        mem_we_s        = is_write_s;
        tx_flit_d.opc   = is_write_s ? OP_WRITE_ACK : OP_READ_RESP;
        tx_flit_d.src_x = MY_X_C;
        tx_flit_d.src_y = MY_Y_C;
        tx_flit_d.dst_x = flit_src_x(req_q);
        tx_flit_d.dst_y = flit_src_y(req_q);
        tx_flit_d.addr  = flit_addr(req_q);
        tx_flit_d.data  = is_write_s ? 32'd0 : mem_q[idx_s];
        lat_d           = LAT_C;
        if (LAT_C != 4'd0) begin
          state_d = S_WAIT;
        end else begin
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        // The counter is loaded with the latency and the WAIT->RESP move
        // happens on the edge where it reads 1, giving RESP_LAT wait cycles.
        if (lat_q <= 4'd1) begin
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      tx_flit_q  <= '0;
      tx_valid_q <= 1'b0;
      lat_q      <= 4'd0;
      req_cnt_q  <= 16'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      tx_flit_q  <= tx_flit_d;
      tx_valid_q <= tx_valid_d;
      lat_q      <= lat_d;
      req_cnt_q  <= req_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Memory array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= flit_data(req_q);
    end
  end

endmodule

// File: tb/tb_yc_noc_mem_responder.sv
// Bench for yc_noc_mem_responder: two instances (RESP_LAT 0 / DEPTH 256 and
// RESP_LAT 3 / DEPTH 16) driven by directed steps and random transactions,
// checked against a transaction-level model of the memory and counters.
module tb_yc_noc_mem_responder;
  import yc_noc_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid [2];
  logic        rx_ready [2];
  flit_t       rx_flit  [2];
  logic        tx_valid [2];
  logic        tx_ready [2];
  flit_t       tx_flit  [2];
  logic        busy     [2];
  logic [15:0] req_cnt  [2];
  logic [15:0] err_cnt  [2];

  int lat_m   [2] = '{0, 3};
  int depth_m [2] = '{256, 16};
  int req_m   [2];
  int err_m   [2];
  logic [31:0] mem_m [int];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  yc_noc_mem_responder #(.MY_X(1), .MY_Y(0), .DEPTH(256), .RESP_LAT(0)) u0 (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .rx_flit(rx_flit[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx_flit(tx_flit[0]),
    .busy(busy[0]), .req_cnt(req_cnt[0]), .err_cnt(err_cnt[0]));

  yc_noc_mem_responder #(.MY_X(1), .MY_Y(0), .DEPTH(16), .RESP_LAT(3)) u1 (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .rx_flit(rx_flit[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx_flit(tx_flit[1]),
    .busy(busy[1]), .req_cnt(req_cnt[1]), .err_cnt(err_cnt[1]));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic flit_t mk(input logic [3:0] opc, input logic [3:0] sx, input logic [3:0] sy,
                               input logic [3:0] dx, input logic [3:0] dy,
                               input logic [31:0] a, input logic [31:0] d);
    flit_t f;
    f.opc = opc; f.src_x = sx; f.src_y = sy; f.dst_x = dx; f.dst_y = dy;
    f.addr = a; f.data = d;
    return f;
  endfunction

  // One complete request on unit u, with 'stall' cycles of tx backpressure.
  task automatic do_req(input int u, input flit_t f, input int stall);
    bit          good;
    bit          wr;
    int          key;
    int          cyc;
    int          bad;
    logic [31:0] rd;
    flit_t       exp_f;
    flit_t       cap;
    good = (f.dst_x == 4'd1) && (f.dst_y == 4'd0) &&
           ((f.opc == OP_READ_REQ) || (f.opc == OP_WRITE_REQ));
    wr   = (f.opc == OP_WRITE_REQ);
    key  = u * 65536 + int'(f.addr & 32'(depth_m[u] - 1));
    @(negedge clk);
    check("rx_ready_idle", rx_ready[u], 1'b1);
    rx_flit[u] = f; rx_valid[u] = 1'b1; tx_ready[u] = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    rx_valid[u] = 1'b0; rx_flit[u] = '0;
    if (!good) begin
      err_m[u]++;
      check("err_cnt", err_cnt[u], 16'(err_m[u]));
      check("req_cnt_on_bad", req_cnt[u], 16'(req_m[u]));
      check("rx_ready_after_bad", rx_ready[u], 1'b1);
      bad = 0;
      repeat (20) begin
        if (tx_valid[u] !== 1'b0) bad++;
        @(negedge clk);
      end
      check("no_resp_for_bad", bad, 0);
      tx_ready[u] = 1'b1;
      return;
    end
    req_m[u]++;
    check("req_cnt", req_cnt[u], 16'(req_m[u]));
    cyc = 1; bad = 0;
    while (tx_valid[u] !== 1'b1 && cyc < 40) begin
      if (busy[u] !== 1'b1 || rx_ready[u] !== 1'b0) bad++;
      @(negedge clk);
      cyc++;
    end
    check("busy_before_resp", bad, 0);
    check("resp_latency", cyc, 2 + lat_m[u]);
    if (wr) mem_m[key] = f.data;
    rd = mem_m.exists(key) ? mem_m[key] : 32'd0;
    exp_f = mk(wr ? OP_WRITE_ACK : OP_READ_RESP, 4'd1, 4'd0, f.src_x, f.src_y,
               f.addr, wr ? 32'd0 : rd);
    check("tx_flit", tx_flit[u], exp_f);
    cap = tx_flit[u]; bad = 0;
    repeat (stall) begin
      if (tx_valid[u] !== 1'b1 || tx_flit[u] !== cap || rx_ready[u] !== 1'b0 || busy[u] !== 1'b1) bad++;
      @(negedge clk);
    end
    if (stall > 0) check("stall_hold", bad, 0);
    tx_ready[u] = 1'b1;
    @(negedge clk);
    check("after_handshake", {tx_valid[u], rx_ready[u], busy[u]}, 3'b010);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int u;
    int pick;
    logic [31:0] a;
    logic [3:0]  op;
    logic [3:0]  dx;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rx_valid[i] = 1'b0; rx_flit[i] = '0; tx_ready[i] = 1'b1;
      req_m[i] = 0; err_m[i] = 0;
    end

    // Reset state.
    @(negedge clk);
    check("rx_ready_in_rst0", rx_ready[0], 1'b0);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_tx_valid", tx_valid[i], 1'b0);
      check("rst_tx_flit", tx_flit[i], '0);
      check("rst_busy", busy[i], 1'b0);
      check("rst_cnts", {req_cnt[i], err_cnt[i]}, 32'd0);
      check("rx_ready_in_rst", rx_ready[i], 1'b0);
    end
    rst = 1'b0;

    // Write then read back, zero latency.
    do_req(0, mk(OP_WRITE_REQ, 4'd0, 4'd0, 4'd1, 4'd0, 32'd4, 32'hDEADBEEF), 0);
    do_req(0, mk(OP_READ_REQ, 4'd0, 4'd0, 4'd1, 4'd0, 32'd4, 32'd0), 0);
    check("req_cnt_two", req_cnt[0], 16'd2);

    // Latency-3 unit.
    do_req(1, mk(OP_WRITE_REQ, 4'd2, 4'd3, 4'd1, 4'd0, 32'd7, 32'hCAFEF00D), 0);
    do_req(1, mk(OP_READ_REQ, 4'd3, 4'd2, 4'd1, 4'd0, 32'd7, 32'd0), 2);

    // Backpressure for 10 cycles.
    do_req(0, mk(OP_READ_REQ, 4'd5, 4'd6, 4'd1, 4'd0, 32'd4, 32'd0), 10);

    // Errors: misrouted then unknown opcode.
    do_req(0, mk(OP_READ_REQ, 4'd0, 4'd0, 4'd2, 4'd0, 32'd4, 32'd0), 0);
    do_req(0, mk(4'hF, 4'd0, 4'd0, 4'd1, 4'd0, 32'd4, 32'd0), 0);
    check("err_two", {req_cnt[0], err_cnt[0]}, {16'd3, 16'd2});

    // Aliasing on both depths.
    do_req(0, mk(OP_WRITE_REQ, 4'd0, 4'd0, 4'd1, 4'd0, 32'h104, 32'h12345678), 0);
    do_req(0, mk(OP_READ_REQ, 4'd0, 4'd0, 4'd1, 4'd0, 32'h004, 32'd0), 0);
    do_req(1, mk(OP_WRITE_REQ, 4'd1, 4'd1, 4'd1, 4'd0, 32'h35, 32'hA5A55A5A), 1);
    do_req(1, mk(OP_READ_REQ, 4'd1, 4'd1, 4'd1, 4'd0, 32'h05, 32'd0), 0);

    // Back-to-back bad flits are consumed one per cycle.
    @(negedge clk);
    rx_flit[0] = mk(OP_WRITE_REQ, 4'd0, 4'd0, 4'd3, 4'd3, 32'd9, 32'd9);
    rx_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      err_m[0]++;
      check("b2b_rx_ready", rx_ready[0], 1'b1);
      check("b2b_err_cnt", err_cnt[0], 16'(err_m[0]));
    end
    rx_valid[0] = 1'b0;

    // Reset while the response is stalled.
    @(negedge clk);
    rx_flit[0] = mk(OP_READ_REQ, 4'd0, 4'd0, 4'd1, 4'd0, 32'd4, 32'd0);
    rx_valid[0] = 1'b1; tx_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rx_valid[0] = 1'b0;
    bad = 0;
    while (tx_valid[0] !== 1'b1 && bad < 40) begin
      @(negedge clk);
      bad++;
    end
    check("pre_rst_resp", tx_valid[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx_valid", tx_valid[0], 1'b0);
    check("rst_mid_cnts", {req_cnt[0], err_cnt[0], req_cnt[1], err_cnt[1]}, 64'd0);
    check("rst_mid_busy_rdy", {busy[0], rx_ready[0]}, 2'b00);
    rst = 1'b0; tx_ready[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_m[i] = 0; err_m[i] = 0;
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid[0] !== 1'b0) bad++;
    end
    check("no_resp_after_rst", bad, 0);
    do_req(0, mk(OP_READ_REQ, 4'd0, 4'd0, 4'd1, 4'd0, 32'd4, 32'd0), 0);

    // Seed low indices on both units so random reads hit known data.
    for (int i = 0; i < 8; i++) begin
      do_req(0, mk(OP_WRITE_REQ, 4'd0, 4'd0, 4'd1, 4'd0, 32'(i), $urandom), 0);
      do_req(1, mk(OP_WRITE_REQ, 4'd0, 4'd0, 4'd1, 4'd0, 32'(i), $urandom), 0);
    end

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      u    = int'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 99));
      op   = (pick < 45) ? OP_WRITE_REQ : (pick < 90) ? OP_READ_REQ : 4'(8 + $urandom_range(0, 7));
      dx   = ($urandom_range(0, 9) == 0) ? 4'd2 : 4'd1;
      a    = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
      do_req(u, mk(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), dx, 4'd0, a, $urandom),
             int'($urandom_range(0, 3)));
    end
    check("final_cnt0", {req_cnt[0], err_cnt[0]}, {16'(req_m[0]), 16'(err_m[0])});
    check("final_cnt1", {req_cnt[1], err_cnt[1]}, {16'(req_m[1]), 16'(err_m[1])});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/yc_noc_mem_responder.md
# yc_noc_mem_responder

NoC target endpoint that terminates CPU-initiated memory requests. It sits at mesh node (MY_X, MY_Y), on the router's local port. It accepts READ_REQ and WRITE_REQ flits, performs the access on an internal word-addressed memory, and returns a READ_RESP or WRITE_ACK flit to the requester's coordinates. It is the responder for the CPU-to-memory round trip exercised at SoC level.

## Interface
Parameters:
- MY_X, 1, this node's mesh X coordinate
- MY_Y, 0, this node's mesh Y coordinate
- DEPTH, 256, memory words; power of two, ≥2
- RESP_LAT, 0, extra wait cycles between memory access and response (0..15)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  request flit valid, from router local output
- rx_ready  out  1  responder can accept a request
- rx_flit  in  flit_t  request flit; fields via yc_noc_defs accessors: opc, src_x/y, dst_x/y, addr, data
- tx_valid  out  1  response flit valid, to router local input
- tx_ready  in  1  router accepts response
- tx_flit  out  flit_t  response flit
- busy  out  1  FSM not in IDLE
- req_cnt  out  16  accepted well-formed requests, saturating
- err_cnt  out  16  dropped flits, saturating

## Operation
- Single outstanding request. FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: rx_ready=1. On rx_valid&&rx_ready, latch rx_flit and classify:
  - Good: dst == (MY_X,MY_Y) and opc ∈ {OP_READ_REQ, OP_WRITE_REQ}. Next state ACCESS; req_cnt+1.
  - Bad: misrouted dst or any other opcode. The flit is consumed with no response; err_cnt+1; stay IDLE.
- ACCESS: index = addr[$clog2(DEPTH)-1:0]; upper address bits are ignored (aliasing).
  - WRITE_REQ: mem[index] <= data.
  - READ_REQ: read data is captured into the response register.
  - Load the latency counter with RESP_LAT. Go to WAIT if RESP_LAT>0, else RESP.
- WAIT: decrement the counter; go to RESP when it reaches 1.
- RESP: tx_valid=1. tx_flit fields:
  - opc = OP_READ_RESP or OP_WRITE_ACK
  - src = (MY_X,MY_Y)
  - dst = latched request src
  - addr = request addr
  - data = read data for reads, 0 for acks
  - On tx_valid&&tx_ready, go to IDLE.
- Counters saturate at 0xFFFF. Counters are never decremented.
- Memory contents are not cleared by rst. Simulation initial contents are all-zero.

## Timing
- Request handshake at edge k. Memory write commits at edge k+1. tx_valid rises after edge k+1+RESP_LAT, i.e. it is first sampled at edge k+2+RESP_LAT.
- After the tx handshake at edge m, the FSM is back in IDLE and rx_ready=1 in the cycle following m.
- Minimum request-to-request spacing is 3+RESP_LAT cycles.
- tx_flit and tx_valid are registered. They hold stable while tx_valid && !tx_ready, for an unbounded stall.
- rx_ready is 0 in every non-IDLE state and while rst=1. No rx_flit is sampled without a handshake.
- rx_valid may drop without a handshake; the responder has no obligation in that case.
- Reset values: state IDLE, tx_valid=0, tx_flit=0, busy=0, req_cnt=0, err_cnt=0. rx_ready=0 during the rst cycle and 1 the cycle after.
- Reset mid-operation (ACCESS, WAIT or RESP) abandons the transaction; no response is ever emitted. A write already committed at ACCESS remains in memory.
- A bad flit in IDLE keeps rx_ready=1, so back-to-back bad flits are consumed one per cycle.

## Test plan
- Write then read, MY=(1,0), RESP_LAT=0:
  - WRITE_REQ src(0,0) dst(1,0) addr 4 data 0xDEADBEEF -> WRITE_ACK src(1,0) dst(0,0) data 0, tx_valid at k+2.
  - Then READ_REQ addr 4 -> READ_RESP src(1,0) dst(0,0) data 0xDEADBEEF. req_cnt=2.
- Latency, RESP_LAT=3: READ_REQ handshake at edge k -> tx_valid first sampled at k+5. busy=1 from k+1 until the tx handshake.
- Backpressure: hold tx_ready=0 for 10 cycles in RESP -> tx_flit unchanged bit-for-bit and rx_ready=0 throughout. The handshake occurs on the first cycle tx_ready=1.
- Errors:
  - READ_REQ dst(2,0) -> consumed, no tx_valid within 20 cycles, err_cnt=1.
  - Unknown opcode -> err_cnt=2, req_cnt unchanged.
- Aliasing, DEPTH=256: write 0x12345678 at addr 0x104, then read addr 0x004 -> data 0x12345678.
- Reset: assert rst for 1 cycle while in RESP -> tx_valid=0 the next cycle, counters 0, and a following READ_REQ completes normally.
